// File: rtl/logic_lut_pkg.sv
// Shared types and constants for the programmable truth-table evaluator.
//   state_t    : evaluator FSM states (IDLE, SETTLE, HOLD)
//   TT_DEFAULT : truth table loaded at reset by default (4-input function)
//   TIMER_W    : width of the settle timer counter
//   tt_w(n)    : truth-table width for an n-input function (2**n)
package logic_lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [15:0] TT_DEFAULT = 16'h2D30;
  localparam int          TIMER_W    = 8;

  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/logic_lut_eval_timer.sv
// Settle timer: 8-bit load/decrement counter.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val into the counter this cycle
//   load_val  : number of cycles to count down
//   done      : high for the single cycle in which the count is 1, i.e. the
//               last cycle of the settle window
module lut_settle_timer
  import logic_lut_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Counter parks at zero once expired, so done cannot repeat.
  assign done = (count_q == TIMER_W'(1));

endmodule

// File: rtl/logic_lut_eval.sv
// Runtime-programmable N_IN-input Boolean function evaluator.
//   clk, rst   : clock, asynchronous active-high reset
//   cfg_we     : load cfg_tt into the truth table at the next edge
//   cfg_tt     : new truth table, bit i = f(i)
//   in_valid / in_ready / in_vec   : input vector stream
//   out_valid / out_ready / out_bit / out_vec : result stream
//   tt_q       : current truth table
//   eval_cnt   : completed output handshakes, saturating
//   dbg_state  : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that
// edge; ready may depend combinationally on the consumer's own state and
// configuration, never on valid. Only one vector is in flight at a time.
module logic_lut_eval
  import logic_lut_pkg::*;
#(
  parameter int                      N_IN          = 4,
  parameter logic [tt_w(N_IN)-1:0]   TT_RESET      = TT_DEFAULT,
  parameter int                      SETTLE_CYCLES = 2,
  parameter int                      CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [tt_w(N_IN)-1:0] cfg_tt,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN-1:0]       in_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic [N_IN-1:0]       out_vec,
  output logic [tt_w(N_IN)-1:0] tt_q,
  output logic [CNT_W-1:0]      eval_cnt,
  output state_t                dbg_state
);

  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES);
  localparam bit                 NO_SETTLE   = (SETTLE_CYCLES == 0);

  state_t          state_q;
  state_t          state_d;
  logic            rdy_q;
  logic            accept;
  logic            timer_load;
  logic            timer_done;
  logic            bit_q;
  logic [N_IN-1:0] vec_q;

  // rdy_q keeps in_ready low during reset and for the first edge after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  // A config write takes priority over a pending vector in IDLE.
  assign in_ready   = (state_q == IDLE) && rdy_q && !cfg_we;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == HOLD);
  assign out_bit    = bit_q;
  assign out_vec    = vec_q;
  assign dbg_state  = state_q;
  assign timer_load = accept && !NO_SETTLE;

  lut_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = NO_SETTLE ? HOLD : SETTLE;
        end
      end
      SETTLE: begin
        if (timer_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_q <= TT_RESET;
    end else if (cfg_we) begin
      tt_q <= cfg_tt;
    end
  end

  // The result is snapshotted at accept, so later table writes cannot
  // disturb a vector already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      bit_q <= 1'b0;
    end else if (accept) begin
      vec_q <= in_vec;
      bit_q <= tt_q[in_vec];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eval_cnt <= '0;
    end else if ((state_q == HOLD) && out_ready && (eval_cnt != '1)) begin
      eval_cnt <= eval_cnt + 1'b1;
    end
  end

endmodule
